spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all logic is synchronous to its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port sclk, input, 1 bit: SPI clock, asynchronous to clk, idles high.
REQ-004 SHALL have port ss, input, 1 bit: slave select, active-high, asynchronous to clk.
REQ-005 SHALL have port mosi, input, 1 bit: master data, MSB first; the master changes it on sclk fall and the slave samples it on sclk rise.
REQ-006 SHALL have port miso, output, 1 bit: slave data, MSB first; the master samples it on sclk rise.
REQ-007 SHALL have port spioe, output, 1 bit: miso output-enable for the top-level tristate.
REQ-008 SHALL have port addr, output, 4 bits: register address of the current transaction.
REQ-009 SHALL have port wr_data, output, 8 bits: write data, valid while wr_stb is high.
REQ-010 SHALL have port wr_stb, output, 1 bit: one-clk write strobe.
REQ-011 SHALL have port rd_stb, output, 1 bit: one-clk read strobe.
REQ-012 SHALL have port rd_data, input, 8 bits: read data; the register file supplies it combinationally and it is valid in the rd_stb cycle.

Function
REQ-013 SHALL pass sclk, ss and mosi through 2-flop synchronizers, and SHALL detect edges only on the synchronized sclk.
REQ-014 SHALL operate correctly for sclk high and low phases each >= 2 clk periods; the miso update latency after a raw sclk rise is <= 3 clk.
REQ-015 SHALL implement the states IDLE, HEADER, DATA and DONE.
REQ-016 IDLE -> HEADER when synchronized ss rises; the 4-bit bit counter and the rx shift register are cleared on that transition.
REQ-017 On each synchronized sclk rise in HEADER or DATA, SHALL shift mosi into the rx register LSB and increment the bit counter.
REQ-018 On the 8th rise, SHALL decode the header {rw, addr[3:0], rsv[2:0]}, register addr, and enter DATA.
REQ-019 If rw=1, SHALL pulse rd_stb for one clk in the decode cycle and load rd_data into the tx register in that same cycle.
REQ-020 miso SHALL equal tx[7] in DATA for read transactions, and SHALL be 0 during HEADER, during write transactions, and in IDLE and DONE.
REQ-021 On each synchronized sclk rise in DATA, SHALL shift the tx register left with a 0 fill, so the next bit is stable before the next master sample.
REQ-022 On the 16th rise with rw=0, SHALL pulse wr_stb for one clk with wr_data = the rx byte and addr held; the state then goes to DONE.
REQ-023 On the 16th rise with rw=1, SHALL go to DONE with no further strobe.
REQ-024 In DONE, extra sclk edges SHALL be ignored, the counter SHALL NOT wrap, and no additional strobes SHALL be issued.
REQ-025 A synchronized ss fall in any state SHALL return to IDLE within 1 clk; a write with fewer than 16 bits is aborted with no wr_stb, and a rd_stb already issued is not retracted.
REQ-026 A simultaneous ss fall and sclk rise SHALL resolve as the ss fall: the bit is discarded.
REQ-027 spioe SHALL equal synchronized ss.
REQ-028 wr_stb and rd_stb SHALL never be high in the same clk, and each SHALL occur at most once per ss assertion.

Reset
REQ-029 While reset is high, SHALL set state=IDLE and clear the counter, rx, tx, addr and wr_data to 0, and hold wr_stb, rd_stb, miso and spioe at 0.
REQ-030 Reset asserted mid-transaction SHALL abort it; after release, a new transaction SHALL begin only on a fresh synchronized ss rise.

Configuration
REQ-031 With macro SPI_SLAVE_HDRCHK_EN defined, a header with rsv != 3'b000 SHALL send the FSM to DONE at the 8th rise with no rd_stb or wr_stb and miso held at 0.
REQ-032 Without SPI_SLAVE_HDRCHK_EN, the rsv bits SHALL be ignored.

Verification
REQ-033 Write addr 0x2, data 0x00 -> exactly one wr_stb, with addr=0x2 and wr_data=0x00, after the 16th sclk rise; no rd_stb.
REQ-034 Write addr 0x0, data 0x80 -> one wr_stb with addr=0x0 and wr_data=0x80.
REQ-035 Read addr 0x0 with rd_data=0x80 -> one rd_stb after the 8th rise; the master shift-in captures 0x00 after byte 1 and 0x80 after byte 2.
REQ-036 ss drops after 12 sclk on a write -> no wr_stb; the next full write to addr 0x1, data 0x55 completes correctly.
REQ-037 20 sclk pulses in one ss window (write addr 0x3, data 0xA5) -> a single wr_stb with data 0xA5; the extra pulses are ignored.
REQ-038 With SPI_SLAVE_HDRCHK_EN defined, header 0x81 -> no strobes and miso=0 for all 16 bits; without the macro, the same header behaves as a read of addr 0x0.

Source files
------------

// File: rtl/spi_slave.sv
// SPI register-access slave: 8-bit header {rw, addr[3:0], rsv[2:0]} followed by one data byte.
// Define SPI_SLAVE_HDRCHK_EN to reject headers whose reserved bits are non-zero.
module spi_slave (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       spioe,
    output logic [3:0] addr,
    output logic [7:0] wr_data,
    output logic       wr_stb,
    output logic       rd_stb,
    input  logic [7:0] rd_data
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, DONE} state_t;

    state_t      state, state_n;
    logic        sclk_meta, sclk_s, sclk_d;
    logic        ss_meta, ss_s, ss_d;
    logic        mosi_meta, mosi_s;
    logic [1:0]  settle;
    logic        armed;
    logic        rise, start, hdr_bad;
    logic        do_shift, do_hdr, do_last;
    logic [3:0]  cnt;
    logic [7:0]  rx, rx_next, tx;
    logic        rw_q;

    // sclk idles high, so its chain resets high to avoid a phantom rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_meta <= 1'b1;
            sclk_s    <= 1'b1;
            sclk_d    <= 1'b1;
            ss_meta   <= 1'b0;
            ss_s      <= 1'b0;
            ss_d      <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
            settle    <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sclk_meta <= sclk;
            sclk_s    <= sclk_meta;
            sclk_d    <= sclk_s;
            ss_meta   <= ss;
            ss_s      <= ss_meta;
            ss_d      <= ss_s;
            mosi_meta <= mosi;
            mosi_s    <= mosi_meta;
            settle    <= {settle[0], 1'b1};
            // A select held high through reset must drop before it can start a transaction.
            if (settle[1] && !ss_s)
                armed <= 1'b1;
        end
    end

    assign rise    = sclk_s & ~sclk_d;
    assign start   = armed & ss_s & ~ss_d;
    assign rx_next = {rx[6:0], mosi_s};

`ifdef SPI_SLAVE_HDRCHK_EN
    assign hdr_bad = |rx_next[2:0];
`else
    assign hdr_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // A dropped select wins over a coincident sclk rise, discarding that bit.
    always_comb begin
        state_n  = state;
        do_shift = 1'b0;
        do_hdr   = 1'b0;
        do_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_n = HEADER;
            end
            HEADER: begin
                if (!ss_s)
                    state_n = IDLE;
                else if (rise) begin
                    do_shift = 1'b1;
                    if (cnt == 4'd7) begin
                        do_hdr  = 1'b1;
                        state_n = hdr_bad ? DONE : DATA;
                    end
                end
            end
            DATA: begin
                if (!ss_s)
                    state_n = IDLE;
                else if (rise) begin
                    do_shift = 1'b1;
                    if (cnt == 4'd15) begin
                        do_last = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (!ss_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        miso  = (state == DATA) & rw_q & tx[7];
        spioe = ss_s;
    end

    // Strobes are registered so addr is already stable when the register file sees rd_stb.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            rx      <= 8'd0;
            tx      <= 8'd0;
            addr    <= 4'd0;
            wr_data <= 8'd0;
            rw_q    <= 1'b0;
            wr_stb  <= 1'b0;
            rd_stb  <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
            if (state == IDLE && start) begin
                cnt  <= 4'd0;
                rx   <= 8'd0;
                tx   <= 8'd0;
                rw_q <= 1'b0;
            end
            if (do_shift) begin
                rx <= rx_next;
                if (cnt != 4'd15)
                    cnt <= cnt + 4'd1;
            end
            if (do_hdr) begin
                addr   <= rx_next[6:3];
                rw_q   <= rx_next[7] & ~hdr_bad;
                rd_stb <= rx_next[7] & ~hdr_bad;
            end
            if (state == DATA && do_shift)
                tx <= {tx[6:0], 1'b0};
            if (rd_stb)
                tx <= rd_data;
            if (do_last && !rw_q) begin
                wr_stb  <= 1'b1;
                wr_data <= rx_next;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: writes, reads, aborts, extra clocks, reset mid-frame, header check.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset, sclk, ss, mosi;
    logic       miso, spioe, wr_stb, rd_stb;
    logic [3:0] addr;
    logic [7:0] wr_data, rd_data;

    int total = 0, passed = 0;
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    int w0, r0;
    logic [3:0]  wr_addr_cap, rd_addr_cap;
    logic [7:0]  wr_data_cap;
    logic [31:0] r;

    spi_slave dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .spioe(spioe), .addr(addr), .wr_data(wr_data),
        .wr_stb(wr_stb), .rd_stb(rd_stb), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) begin
            wr_cnt++;
            wr_addr_cap = addr;
            wr_data_cap = wr_data;
        end
        if (rd_stb) begin
            rd_cnt++;
            rd_addr_cap = addr;
        end
        if (wr_stb && rd_stb)
            both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    // Master: drive mosi on the falling sclk edge, sample miso at the rising edge.
    task automatic bits(input logic [31:0] d, input int n, output logic [31:0] rr);
        rr = 0;
        for (int i = n - 1; i >= 0; i--) begin
            sclk = 1'b0;
            mosi = d[i];
            half();
            rr = {rr[30:0], miso};
            sclk = 1'b1;
            half();
        end
    endtask

    task automatic xfer(input logic [31:0] d, input int n, output logic [31:0] rr);
        ss = 1'b1;
        half();
        bits(d, n, rr);
        ss = 1'b0;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic snap();
        w0 = wr_cnt;
        r0 = rd_cnt;
    endtask

    initial begin
        reset = 1'b1; sclk = 1'b1; ss = 1'b0; mosi = 1'b0; rd_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_spioe", spioe, 0);
        check("rst_strobes", {wr_stb, rd_stb}, 0);
        check("rst_addr", addr, 0);
        check("rst_wr_data", wr_data, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // write addr 2, data 0x00
        snap();
        xfer(32'h1000, 16, r);
        check("w2_wr_cnt", wr_cnt - w0, 1);
        check("w2_rd_cnt", rd_cnt - r0, 0);
        check("w2_addr", wr_addr_cap, 4'h2);
        check("w2_data", wr_data_cap, 8'h00);
        check("w2_miso_zero", r, 0);
        check("w2_addr_held", addr, 4'h2);
        check("idle_spioe", spioe, 0);

        // write addr 0, data 0x80
        snap();
        xfer(32'h0080, 16, r);
        check("w0_wr_cnt", wr_cnt - w0, 1);
        check("w0_addr", wr_addr_cap, 4'h0);
        check("w0_data", wr_data_cap, 8'h80);

        // read addr 0, rd_data 0x80
        rd_data = 8'h80;
        snap();
        xfer(32'h8000, 16, r);
        check("r0_shift_in", r, 32'h0080);
        check("r0_rd_cnt", rd_cnt - r0, 1);
        check("r0_wr_cnt", wr_cnt - w0, 0);
        check("r0_addr", rd_addr_cap, 4'h0);

        // read addr 5, rd_data 0xC3
        rd_data = 8'hC3;
        snap();
        xfer(32'hA800, 16, r);
        check("r5_shift_in", r, 32'h00C3);
        check("r5_rd_cnt", rd_cnt - r0, 1);
        check("r5_addr", rd_addr_cap, 4'h5);

        // aborted write after 12 bits, then full write addr 1 data 0x55
        snap();
        xfer(32'h08F, 12, r);
        check("abort_wr_cnt", wr_cnt - w0, 0);
        snap();
        xfer(32'h0855, 16, r);
        check("w1_wr_cnt", wr_cnt - w0, 1);
        check("w1_addr", wr_addr_cap, 4'h1);
        check("w1_data", wr_data_cap, 8'h55);

        // 20 sclk pulses: write addr 3 data 0xA5 plus 4 extra
        snap();
        xfer(32'h18A5F, 20, r);
        check("x20_wr_cnt", wr_cnt - w0, 1);
        check("x20_addr", wr_addr_cap, 4'h3);
        check("x20_data", wr_data_cap, 8'hA5);
        check("x20_miso_zero", r, 0);

        // ss fall coincident with the 16th rise discards the bit
        snap();
        ss = 1'b1;
        half();
        bits(32'h1008, 15, r);
        sclk = 1'b0;
        mosi = 1'b1;
        half();
        sclk = 1'b1;
        ss = 1'b0;
        repeat (8) @(negedge clk);
        check("coinc_wr_cnt", wr_cnt - w0, 0);

        // header 0x81 (reserved bits non-zero)
        rd_data = 8'h80;
        snap();
        xfer(32'h8100, 16, r);
`ifdef SPI_SLAVE_HDRCHK_EN
        check("h81_shift_in", r, 0);
        check("h81_rd_cnt", rd_cnt - r0, 0);
`else
        check("h81_shift_in", r, 32'h0080);
        check("h81_rd_cnt", rd_cnt - r0, 1);
`endif
        check("h81_wr_cnt", wr_cnt - w0, 0);

        // reset mid-write; frame completion after release must not start a transaction
        snap();
        ss = 1'b1;
        half();
        check("busy_spioe", spioe, 1);
        bits(32'h061, 10, r);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_addr", addr, 0);
        check("midrst_spioe", spioe, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        bits(32'h37, 6, r);
        half();
        check("midrst_wr_cnt", wr_cnt - w0, 0);
        ss = 1'b0;
        repeat (8) @(negedge clk);
        snap();
        xfer(32'h1877, 16, r);
        check("post_rst_wr_cnt", wr_cnt - w0, 1);
        check("post_rst_data", wr_data_cap, 8'h77);

        check("never_both_strobes", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
